// File: rtl/mult_share_arb_pkg.sv
// Shared types and constants for the shared-multiplier arbiter.
// Holds the FSM encodings, the requester-ID width helper and the statistics counter width.
package mult_share_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int STAT_W = 16;

   // Width of a requester ID; never below one bit.
   function automatic int id_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/mult_share_rr_pick.sv
// Rotating-priority picker: first set request at or above rr_ptr, with wrap.
// Purely combinational; produces the one-hot grant, the winner index and an any flag.
module mult_share_rr_pick
   import mult_share_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   int j;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(rr_ptr) + k) % NUM_REQ;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin share of one pipelined multiplier; result after PIPE unstalled edges, 1 op/cycle.
// A result its owner will not take freezes the multiplier and tag pipe via clken; optional stats: MULT_SHARE_ARB_STATS_EN.
module mult_share_arb
   import mult_share_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTHA  = 16,
   parameter int WIDTHB  = 16,
   parameter int WIDTHP  = 32,
   parameter int PIPE    = 2
) (
   input  logic                        clock,
   input  logic                        sclr,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*WIDTHA-1:0]   req_dataa,
   input  logic [NUM_REQ*WIDTHB-1:0]   req_datab,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_REQ-1:0]          resp_valid,
   output logic [WIDTHP-1:0]           resp_data,
   input  logic [NUM_REQ-1:0]          resp_ready,
   input  logic                        drain_req,
   output logic                        drain_done,
   output logic [WIDTHA-1:0]           mult_dataa,
   output logic [WIDTHB-1:0]           mult_datab,
   output logic                        mult_clken,
   input  logic [WIDTHP-1:0]           mult_result
`ifdef MULT_SHARE_ARB_STATS_EN
  ,input  logic [2:0]                  stat_sel,
   output logic [STAT_W-1:0]           stat_cnt
`endif
);

   localparam int ID_W = id_w(NUM_REQ);

   if (PIPE < 1 || PIPE > 8) begin : g_bad_pipe
      $fatal(1, "mult_share_arb: PIPE must be 1..8");
   end
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $fatal(1, "mult_share_arb: NUM_REQ must be 2..8");
   end

   state_t              state, state_nxt;
   logic [ID_W-1:0]     rr_ptr;
   logic [PIPE-1:0]     tag_v;
   logic [ID_W-1:0]     tag_id [PIPE];
   logic [NUM_REQ-1:0]  win_gnt;
   logic [ID_W-1:0]     win_idx;
   logic                win_any;
   logic                out_v;
   logic [ID_W-1:0]     out_id;
   logic                stall;
   logic                grant_en;
   logic                grant;

   mult_share_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req    (req_valid),
      .rr_ptr (rr_ptr),
      .gnt    (win_gnt),
      .idx    (win_idx),
      .any    (win_any)
   );

   assign out_v      = tag_v[PIPE-1];
   assign out_id     = tag_id[PIPE-1];
   assign stall      = out_v & ~resp_ready[out_id];
   assign mult_clken = ~sclr & ~stall;
   assign resp_data  = mult_result;
   assign grant      = grant_en & win_any;
   assign req_ready  = grant ? win_gnt : '0;
   assign mult_dataa = grant ? req_dataa[win_idx*WIDTHA +: WIDTHA] : '0;
   assign mult_datab = grant ? req_datab[win_idx*WIDTHB +: WIDTHB] : '0;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         resp_valid[i] = ~sclr & out_v & (out_id == ID_W'(i));
      end
   end

   always_ff @(posedge clock) begin
      if (sclr) begin
         state  <= IDLE;
         rr_ptr <= '0;
         tag_v  <= '0;
         for (int s = 0; s < PIPE; s++) tag_id[s] <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            rr_ptr <= (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + ID_W'(1);
         end
         if (mult_clken) begin
            tag_v[0]  <= grant;
            tag_id[0] <= win_idx;
            for (int s = 1; s < PIPE; s++) begin
               tag_v[s]  <= tag_v[s-1];
               tag_id[s] <= tag_id[s-1];
            end
         end
      end
   end

   // IDLE grants in the same cycle as RUN would, so a first request costs no extra cycle.
   always_comb begin
      state_nxt  = state;
      grant_en   = ~sclr & ~stall & ~drain_req & (state != DRAIN);
      drain_done = ~sclr & (state == DRAIN) & ~|tag_v;
      case (state)
         IDLE: begin
            if (drain_req)       state_nxt = DRAIN;
            else if (|req_valid) state_nxt = RUN;
         end
         RUN: begin
            if (drain_req)                      state_nxt = DRAIN;
            else if (~|tag_v && ~|req_valid)    state_nxt = IDLE;
         end
         DRAIN: begin
            if (!drain_req) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef MULT_SHARE_ARB_STATS_EN
   logic [STAT_W-1:0] grant_cnt [NUM_REQ];

   always_ff @(posedge clock) begin
      if (sclr) begin
         for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
         stat_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i] && grant_cnt[i] != '1) begin
               grant_cnt[i] <= grant_cnt[i] + STAT_W'(1);
            end
         end
         stat_cnt <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (32'(stat_sel) == i) stat_cnt <= grant_cnt[i];
         end
      end
   end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: directed literal cases plus randomized traffic against a queue-based model.
module tb_mult_share_arb;

   localparam int N  = 4;
   localparam int WA = 16;
   localparam int WB = 16;
   localparam int WP = 32;
   localparam int P  = 2;

   logic              clock = 1'b0;
   logic              sclr;
   logic [N-1:0]      req_valid;
   logic [N*WA-1:0]   req_dataa;
   logic [N*WB-1:0]   req_datab;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      resp_valid;
   logic [WP-1:0]     resp_data;
   logic [N-1:0]      resp_ready;
   logic              drain_req;
   logic              drain_done;
   logic [WA-1:0]     mult_dataa;
   logic [WB-1:0]     mult_datab;
   logic              mult_clken;
   logic [WP-1:0]     mult_result;
`ifdef MULT_SHARE_ARB_STATS_EN
   logic [2:0]        stat_sel;
   logic [15:0]       stat_cnt;
`endif

   int checks = 0;
   int errors = 0;

   mult_share_arb #(
      .NUM_REQ (N), .WIDTHA (WA), .WIDTHB (WB), .WIDTHP (WP), .PIPE (P)
   ) dut (
      .clock       (clock),
      .sclr        (sclr),
      .req_valid   (req_valid),
      .req_dataa   (req_dataa),
      .req_datab   (req_datab),
      .req_ready   (req_ready),
      .resp_valid  (resp_valid),
      .resp_data   (resp_data),
      .resp_ready  (resp_ready),
      .drain_req   (drain_req),
      .drain_done  (drain_done),
      .mult_dataa  (mult_dataa),
      .mult_datab  (mult_datab),
      .mult_clken  (mult_clken),
      .mult_result (mult_result)
`ifdef MULT_SHARE_ARB_STATS_EN
     ,.stat_sel    (stat_sel),
      .stat_cnt    (stat_cnt)
`endif
   );

   always #5 clock = ~clock;

   // Stand-in for the lpm_mult: P registered stages, frozen when clken is low.
   logic [WP-1:0] mpipe [P];
   initial for (int s = 0; s < P; s++) mpipe[s] = '0;
   always @(posedge clock) begin
      if (mult_clken) begin
         mpipe[0] <= 32'(mult_dataa) * 32'(mult_datab);
         for (int s = 1; s < P; s++) mpipe[s] <= mpipe[s-1];
      end
   end
   assign mult_result = mpipe[P-1];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: in-flight ops in issue order, each with the count of pipe advances it has seen.
   typedef struct {
      int          id;
      logic [31:0] prod;
      int          age;
   } op_t;

   op_t         q[$];
   int          m_rr = 0;
   bit          m_pdrain = 1'b0;
   bit          m_out, m_stall, m_clk, m_done;
   int          m_win;
   logic [N-1:0] e_ready, e_rv;
   logic [WA-1:0] e_a;
   logic [WB-1:0] e_b;

   always @(negedge clock) begin
      m_out   = (q.size() > 0) && (q[0].age == P);
      m_stall = m_out && !resp_ready[q[0].id];
      m_clk   = !sclr && !m_stall;
      e_rv    = (!sclr && m_out) ? (N'(1) << q[0].id) : '0;
      m_win   = -1;
      if (!sclr && !m_stall && !drain_req && !m_pdrain) begin
         for (int k = 0; k < N; k++) begin
            if (m_win < 0 && req_valid[(m_rr + k) % N]) m_win = (m_rr + k) % N;
         end
      end
      e_ready = (m_win >= 0) ? (N'(1) << m_win) : '0;
      e_a     = (m_win >= 0) ? req_dataa[m_win*WA +: WA] : '0;
      e_b     = (m_win >= 0) ? req_datab[m_win*WB +: WB] : '0;
      m_done  = !sclr && m_pdrain && (q.size() == 0);

      chk("m_req_ready", 64'(req_ready), 64'(e_ready));
      chk("m_resp_valid", 64'(resp_valid), 64'(e_rv));
      chk("m_clken", 64'(mult_clken), 64'(m_clk));
      chk("m_drain_done", 64'(drain_done), 64'(m_done));
      chk("m_dataa", 64'(mult_dataa), 64'(e_a));
      chk("m_datab", 64'(mult_datab), 64'(e_b));
      if (e_rv != '0) chk("m_resp_data", 64'(resp_data), 64'(q[0].prod));

      if (sclr) begin
         q.delete();
         m_rr     = 0;
         m_pdrain = 1'b0;
      end else begin
         if (m_clk) begin
            if (m_out) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (m_win >= 0) q.push_back('{m_win, 32'(e_a) * 32'(e_b), 1});
         end
         if (m_win >= 0) m_rr = (m_win + 1) % N;
         m_pdrain = drain_req;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ops(input int i, input int a, input int b);
      req_dataa[i*WA +: WA] = WA'(a);
      req_datab[i*WB +: WB] = WB'(b);
   endtask

   // Two reset cycles with every requester asking; returns at the start of the first post-reset cycle.
   task automatic do_reset();
      sclr = 1'b1; req_valid = '1; drain_req = 1'b0; resp_ready = '1;
      tick();
      #3;
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_resp_valid", 64'(resp_valid), 64'(0));
      chk("rst_clken", 64'(mult_clken), 64'(0));
      chk("rst_drain_done", 64'(drain_done), 64'(0));
      tick();
      sclr = 1'b0; req_valid = '0;
   endtask

   initial begin
      sclr = 1'b1; req_valid = '0; req_dataa = '0; req_datab = '0;
      resp_ready = '1; drain_req = 1'b0;
`ifdef MULT_SHARE_ARB_STATS_EN
      stat_sel = '0;
`endif

      // Basic latency
      do_reset();
      set_ops(0, 3, 5);
      req_valid = 4'b0001; #3;
      chk("lat_ready", 64'(req_ready), 64'(1));
      chk("lat_dataa", 64'(mult_dataa), 64'(3));
      tick();
      req_valid = '0;
      tick();
      #3;
      chk("lat_resp_valid", 64'(resp_valid), 64'(1));
      chk("lat_resp_data", 64'(resp_data), 64'(15));
      tick();

      // Rotation with all requesters valid
      do_reset();
      for (int i = 0; i < N; i++) set_ops(i, i + 1, 10);
      for (int k = 0; k < 10; k++) begin
         req_valid = (k < 8) ? 4'b1111 : 4'b0000; #3;
         if (k < 8) chk("rot_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
         if (k >= 2) begin
            chk("rot_resp_valid", 64'(resp_valid), 64'(4'b0001 << ((k - 2) % 4)));
            chk("rot_resp_data", 64'(resp_data), 64'(((k - 2) % 4 + 1) * 10));
         end
         tick();
      end

      // Back-pressure
      do_reset();
      set_ops(0, 1, 1); set_ops(1, 7, 9); set_ops(2, 2, 2);
      req_valid = 4'b0010; #3;
      chk("bp_ready1", 64'(req_ready), 64'(4'b0010));
      tick();
      req_valid = 4'b0100; #3;
      chk("bp_ready2", 64'(req_ready), 64'(4'b0100));
      tick();
      for (int k = 0; k < 3; k++) begin
         req_valid = 4'b0001; resp_ready = 4'b1101; #3;
         chk("bp_clken_low", 64'(mult_clken), 64'(0));
         chk("bp_hold_valid", 64'(resp_valid), 64'(4'b0010));
         chk("bp_hold_data", 64'(resp_data), 64'(63));
         chk("bp_no_grant", 64'(req_ready), 64'(0));
         tick();
      end
      resp_ready = '1; #3;
      chk("bp_release_clken", 64'(mult_clken), 64'(1));
      chk("bp_release_data", 64'(resp_data), 64'(63));
      chk("bp_waiting_grant", 64'(req_ready), 64'(4'b0001));
      tick();
      req_valid = '0; #3;
      chk("bp_second_valid", 64'(resp_valid), 64'(4'b0100));
      chk("bp_second_data", 64'(resp_data), 64'(4));
      tick();
      #3;
      chk("bp_third_data", 64'(resp_data), 64'(1));
      tick();

      // Drain with two ops in flight
      do_reset();
      set_ops(0, 2, 3); set_ops(1, 4, 4);
      req_valid = 4'b0001; #3; tick();
      req_valid = 4'b0010; #3; tick();
      drain_req = 1'b1; req_valid = 4'b1111; #3;
      chk("dr_ready0", 64'(req_ready), 64'(0));
      chk("dr_data0", 64'(resp_data), 64'(6));
      chk("dr_done0", 64'(drain_done), 64'(0));
      tick();
      #3;
      chk("dr_ready1", 64'(req_ready), 64'(0));
      chk("dr_done1", 64'(drain_done), 64'(0));
      chk("dr_data1", 64'(resp_data), 64'(16));
      tick();
      #3;
      chk("dr_done2", 64'(drain_done), 64'(1));
      tick();
      drain_req = 1'b0; #3;
      chk("dr_exit_ready", 64'(req_ready), 64'(0));
      tick();
      #3;
      chk("dr_resume_ready", 64'(req_ready), 64'(4'b0100));
      tick();
      req_valid = '0;

      // Reset with ops in flight
      do_reset();
      set_ops(1, 5, 5); set_ops(2, 6, 6);
      req_valid = 4'b0010; #3; tick();
      req_valid = 4'b0100; #3; tick();
      sclr = 1'b1; req_valid = '0; #3;
      chk("mr_valid_in_rst", 64'(resp_valid), 64'(0));
      tick();
      sclr = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #3;
         chk("mr_no_stale", 64'(resp_valid), 64'(0));
         tick();
      end
      req_valid = 4'b1111; #3;
      chk("mr_first_grant", 64'(req_ready), 64'(4'b0001));
      tick();
      req_valid = '0;

`ifdef MULT_SHARE_ARB_STATS_EN
      do_reset();
      req_valid = 4'b1000;
      for (int k = 0; k < 5; k++) tick();
      req_valid = '0; stat_sel = 3'd3;
      tick();
      #3;
      chk("stat_req3", 64'(stat_cnt), 64'(5));
      stat_sel = 3'd6;
      tick();
      #3;
      chk("stat_out_of_range", 64'(stat_cnt), 64'(0));
      tick();
`endif

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         req_valid = N'($urandom);
         for (int i = 0; i < N; i++) begin
            set_ops(i, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
            resp_ready[i] = ($urandom_range(0, 3) != 0);
         end
         if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
         sclr = ($urandom_range(0, 199) == 0);
         tick();
      end
      sclr = 1'b0; drain_req = 1'b0; req_valid = '0; resp_ready = '1;
      for (int c = 0; c < 2 * P + 4; c++) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
